// File: rtl/wr_err_responder.sv
// AXI write-channel error responder: accepts AW/W while isolating and answers every burst with
// SLVERR, in order. Optional B-handshake counter on err_cnt_o when WR_ERR_RESP_CNT_EN is defined.
module wr_err_responder #(
    parameter int unsigned MaxWrTxns = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned LenWidth  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                active_i,
    input  logic                aw_valid_i,
    input  logic [IdWidth-1:0]  aw_id_i,
    input  logic [LenWidth-1:0] aw_len_i,
    output logic                aw_ready_o,
    input  logic                w_valid_i,
    input  logic                w_last_i,
    output logic                w_ready_o,
    output logic                b_valid_o,
    output logic [IdWidth-1:0]  b_id_o,
    output logic [1:0]          b_resp_o,
    input  logic                b_ready_i,
    output logic                busy_o,
    output logic                drained_o,
    output logic                err_o
`ifdef WR_ERR_RESP_CNT_EN
    ,
    output logic [15:0]         err_cnt_o
`endif
);

    localparam int unsigned IdxW = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(MaxWrTxns - 1);

    typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

    state_e state_q, state_d;

    // Pointers carry an extra wrap bit above the index so full and empty differ.
    logic [IdxW:0] aw_wr_q, aw_rd_q, b_wr_q, b_rd_q;
    logic [IdWidth-1:0]  aw_id_mem [MaxWrTxns];
    logic [LenWidth-1:0] aw_len_mem [MaxWrTxns];
    logic [IdWidth-1:0]  b_id_mem [MaxWrTxns];

    logic [LenWidth:0] beat_cnt_q, beat_cnt_d;
    logic              err_q, drained_q;

    logic aw_empty, aw_full, b_empty, b_full;
    logic aw_push, aw_pop, b_push, b_pop;
    logic w_hs, at_len, burst_done;
    logic [IdWidth-1:0]  head_id;
    logic [LenWidth-1:0] head_len;

    function automatic logic [IdxW:0] ptr_inc(input logic [IdxW:0] p);
        if (p[IdxW-1:0] == LastIdx) begin
            return {~p[IdxW], {IdxW{1'b0}}};
        end
        return p + (IdxW+1)'(1);
    endfunction

    assign aw_empty = (aw_wr_q == aw_rd_q);
    assign aw_full  = (aw_wr_q[IdxW-1:0] == aw_rd_q[IdxW-1:0]) && (aw_wr_q[IdxW] != aw_rd_q[IdxW]);
    assign b_empty  = (b_wr_q == b_rd_q);
    assign b_full   = (b_wr_q[IdxW-1:0] == b_rd_q[IdxW-1:0]) && (b_wr_q[IdxW] != b_rd_q[IdxW]);

    assign head_id  = aw_id_mem[aw_rd_q[IdxW-1:0]];
    assign head_len = aw_len_mem[aw_rd_q[IdxW-1:0]];

    assign aw_ready_o = (state_q == StActive) && !aw_full;
    assign w_ready_o  = !aw_empty && (state_q != StIdle) && !b_full;
    assign b_valid_o  = !b_empty;
    assign b_id_o     = b_empty ? '0 : b_id_mem[b_rd_q[IdxW-1:0]];
    assign b_resp_o   = b_empty ? 2'b00 : 2'b10;
    assign busy_o     = (state_q != StIdle);
    assign drained_o  = drained_q;
    assign err_o      = err_q;

    assign aw_push    = aw_valid_i && aw_ready_o;
    assign w_hs       = w_valid_i && w_ready_o;
    assign at_len     = (beat_cnt_q == {1'b0, head_len});
    assign burst_done = w_hs && (at_len || w_last_i);
    assign aw_pop     = burst_done;
    assign b_push     = burst_done;
    assign b_pop      = b_valid_o && b_ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (active_i) state_d = StActive;
            StActive: if (!active_i) state_d = StFlush;
            StFlush: begin
                if (active_i) begin
                    state_d = StActive;
                end else if (aw_empty && b_empty && (beat_cnt_q == '0)) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (burst_done) begin
            beat_cnt_d = '0;
        end else if (w_hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            aw_wr_q    <= '0;
            aw_rd_q    <= '0;
            b_wr_q     <= '0;
            b_rd_q     <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            drained_q  <= (state_q == StFlush) && (state_d == StIdle);
            if (w_hs && (w_last_i != at_len)) err_q <= 1'b1;
            if (aw_push) aw_wr_q <= ptr_inc(aw_wr_q);
            if (aw_pop)  aw_rd_q <= ptr_inc(aw_rd_q);
            if (b_push)  b_wr_q  <= ptr_inc(b_wr_q);
            if (b_pop)   b_rd_q  <= ptr_inc(b_rd_q);
        end
    end

    // Storage needs no reset: empty queues mask their contents.
    always_ff @(posedge clk_i) begin
        if (aw_push) begin
            aw_id_mem[aw_wr_q[IdxW-1:0]]  <= aw_id_i;
            aw_len_mem[aw_wr_q[IdxW-1:0]] <= aw_len_i;
        end
        if (b_push) begin
            b_id_mem[b_wr_q[IdxW-1:0]] <= head_id;
        end
    end

`ifdef WR_ERR_RESP_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (b_pop && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_wr_err_responder.sv
// Directed bench for wr_err_responder: single beat, ordering, full queue, early last, flush and
// mid-operation reset, checked with immediate assertions.
module tb_wr_err_responder;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       active_i = 1'b0;
    logic       aw_valid_i = 1'b0;
    logic [3:0] aw_id_i = '0;
    logic [7:0] aw_len_i = '0;
    logic       aw_ready_o;
    logic       w_valid_i = 1'b0;
    logic       w_last_i = 1'b0;
    logic       w_ready_o;
    logic       b_valid_o;
    logic [3:0] b_id_o;
    logic [1:0] b_resp_o;
    logic       b_ready_i = 1'b0;
    logic       busy_o;
    logic       drained_o;
    logic       err_o;
`ifdef WR_ERR_RESP_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wr_err_responder dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .active_i   (active_i),
        .aw_valid_i (aw_valid_i),
        .aw_id_i    (aw_id_i),
        .aw_len_i   (aw_len_i),
        .aw_ready_o (aw_ready_o),
        .w_valid_i  (w_valid_i),
        .w_last_i   (w_last_i),
        .w_ready_o  (w_ready_o),
        .b_valid_o  (b_valid_o),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .b_ready_i  (b_ready_i),
        .busy_o     (busy_o),
        .drained_o  (drained_o),
        .err_o      (err_o)
`ifdef WR_ERR_RESP_CNT_EN
        ,
        .err_cnt_o  (err_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [7:0] len);
        chk("aw_ready before push", {31'd0, aw_ready_o}, 32'd1);
        aw_valid_i = 1'b1;
        aw_id_i    = id;
        aw_len_i   = len;
        tick();
        aw_valid_i = 1'b0;
    endtask

    task automatic do_w(input logic last);
        chk("w_ready before beat", {31'd0, w_ready_o}, 32'd1);
        w_valid_i = 1'b1;
        w_last_i  = last;
        tick();
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst aw_ready", {31'd0, aw_ready_o}, 32'd0);
        chk("rst w_ready", {31'd0, w_ready_o}, 32'd0);
        chk("rst b_valid", {31'd0, b_valid_o}, 32'd0);
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst drained", {31'd0, drained_o}, 32'd0);
        chk("rst err", {31'd0, err_o}, 32'd0);
        chk("rst b_id", {28'd0, b_id_o}, 32'd0);
        chk("rst b_resp", {30'd0, b_resp_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        chk("idle busy", {31'd0, busy_o}, 32'd0);

        // Single beat
        active_i = 1'b1;
        tick();
        chk("active busy", {31'd0, busy_o}, 32'd1);
        chk("w_ready no aw", {31'd0, w_ready_o}, 32'd0);
        b_ready_i = 1'b1;
        do_aw(4'd3, 8'd0);
        chk("b_valid before beat", {31'd0, b_valid_o}, 32'd0);
        do_w(1'b1);
        chk("single b_valid", {31'd0, b_valid_o}, 32'd1);
        chk("single b_id", {28'd0, b_id_o}, 32'd3);
        chk("single b_resp", {30'd0, b_resp_o}, 32'd2);
        tick();
        chk("single popped", {31'd0, b_valid_o}, 32'd0);

        // Ordering
        b_ready_i = 1'b0;
        do_aw(4'd1, 8'd3);
        do_aw(4'd2, 8'd0);
        do_aw(4'd5, 8'd1);
        do_w(1'b0); do_w(1'b0); do_w(1'b0); do_w(1'b1);
        do_w(1'b1);
        do_w(1'b0); do_w(1'b1);
        tick();
        chk("order hold b_id", {28'd0, b_id_o}, 32'd1);
        chk("order hold b_valid", {31'd0, b_valid_o}, 32'd1);
        b_ready_i = 1'b1;
        tick();
        chk("order b_id 2", {28'd0, b_id_o}, 32'd2);
        tick();
        chk("order b_id 5", {28'd0, b_id_o}, 32'd5);
        tick();
        chk("order empty", {31'd0, b_valid_o}, 32'd0);
        chk("order no err", {31'd0, err_o}, 32'd0);

        // Full AW queue
        b_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) do_aw(4'(i), 8'd0);
        chk("full aw_ready", {31'd0, aw_ready_o}, 32'd0);
        b_ready_i = 1'b1;
        do_w(1'b1);
        chk("full aw_ready again", {31'd0, aw_ready_o}, 32'd1);
        chk("full b_id 0", {28'd0, b_id_o}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            do_w(1'b1);
            chk("full b_id seq", {28'd0, b_id_o}, 32'(i % 16));
        end
        tick();
        chk("full drained b", {31'd0, b_valid_o}, 32'd0);
        chk("full w_ready", {31'd0, w_ready_o}, 32'd0);

        // Early last
        b_ready_i = 1'b0;
        do_aw(4'd7, 8'd3);
        do_w(1'b0);
        do_w(1'b0);
        chk("early err before", {31'd0, err_o}, 32'd0);
        do_w(1'b1);
        chk("early b_valid", {31'd0, b_valid_o}, 32'd1);
        chk("early b_id", {28'd0, b_id_o}, 32'd7);
        chk("early err", {31'd0, err_o}, 32'd1);
        chk("early w_ready", {31'd0, w_ready_o}, 32'd0);
        b_ready_i = 1'b1;
        tick();
        chk("early popped", {31'd0, b_valid_o}, 32'd0);
        chk("early err sticky", {31'd0, err_o}, 32'd1);

        // Flush
        b_ready_i = 1'b0;
        do_aw(4'd8, 8'd1);
        do_aw(4'd9, 8'd0);
        active_i = 1'b0;
        tick();
        chk("flush aw_ready", {31'd0, aw_ready_o}, 32'd0);
        chk("flush busy", {31'd0, busy_o}, 32'd1);
        do_w(1'b0);
        do_w(1'b1);
        do_w(1'b1);
        chk("flush b_id 8", {28'd0, b_id_o}, 32'd8);
        chk("flush no drain yet", {31'd0, drained_o}, 32'd0);
        b_ready_i = 1'b1;
        tick();
        chk("flush b_id 9", {28'd0, b_id_o}, 32'd9);
        tick();
        chk("flush b empty", {31'd0, b_valid_o}, 32'd0);
        chk("flush still busy", {31'd0, busy_o}, 32'd1);
        chk("flush drained low", {31'd0, drained_o}, 32'd0);
        tick();
        chk("flush drained pulse", {31'd0, drained_o}, 32'd1);
        chk("flush idle", {31'd0, busy_o}, 32'd0);
        tick();
        chk("flush drained once", {31'd0, drained_o}, 32'd0);
        chk("flush err sticky", {31'd0, err_o}, 32'd1);

        // Mid-operation reset
        active_i = 1'b1;
        b_ready_i = 1'b0;
        tick();
        do_aw(4'd4, 8'd0);
        do_w(1'b1);
        chk("mid b pending", {31'd0, b_valid_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        chk("mid rst b_valid", {31'd0, b_valid_o}, 32'd0);
        chk("mid rst err", {31'd0, err_o}, 32'd0);
        chk("mid rst busy", {31'd0, busy_o}, 32'd0);
        chk("mid rst b_id", {28'd0, b_id_o}, 32'd0);
        rst_i = 1'b0;
        b_ready_i = 1'b1;
        tick();
        tick();
        chk("mid no b after", {31'd0, b_valid_o}, 32'd0);
        chk("mid busy again", {31'd0, busy_o}, 32'd1);
        chk("mid w_ready", {31'd0, w_ready_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
